console_mem_ctrl: RTL and testbench

- Front-panel console controller for the PDP8 core. Implements the Load Address (LA), Deposit (DEP) and Examine (EXAM) console functions.
- Arbitrates the single RAM port between the CPU datapath and the console. The console may take the port only while the CPU is halted.
- Holds the console MA/MB registers for panel display. Sits between the FrontPanel button/switch outputs, the Sequencer run control and the RAM.

---
 rtl/pdp8_console_pkg.sv | 31 +++
 rtl/btn_sync_edge.sv | 27 ++
 rtl/console_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_console_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_console_pkg.sv
// Shared types for the PDP8 front-panel console: FSM states, console op codes
// and the machine word width.
package pdp8_console_pkg;

  localparam int WORD_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LA,
    ST_DEP_WR,
    ST_EX_RD,
    ST_EX_CAP,
    ST_INC
  } console_state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_LA,
    OP_DEP,
    OP_EXAM
  } console_op_e;

  // Simultaneous button edges resolve LA > DEP > EXAM; losers are dropped.
  function automatic console_op_e pick_op(input logic la, input logic dep, input logic exam);
    if (la)        return OP_LA;
    else if (dep)  return OP_DEP;
    else if (exam) return OP_EXAM;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchroniser for an asynchronous button level, followed by a
// registered rising-edge detector producing a one-cycle pulse.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], din};
      prev  <= sync[STAGES-1];
      pulse <= sync[STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/console_mem_ctrl.sv
// Front-panel LA/DEP/EXAM controller: owns the console MA/MB registers and
// borrows the single RAM port from the CPU while the CPU is halted.
module console_mem_ctrl
  import pdp8_console_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_running,
  input  logic [11:0] sw,
  input  logic        btn_la,
  input  logic        btn_dep,
  input  logic        btn_exam,
  input  logic [11:0] cpu_ram_addr,
  input  logic [11:0] cpu_ram_wdata,
  input  logic        cpu_ram_we,
  input  logic        cpu_ram_oe,
  input  logic [11:0] ram_rdata,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_oe,
  output logic        console_owns,
  output logic        cpu_stall,
  output logic [11:0] ma,
  output logic [11:0] mb,
  output logic [2:0]  dbg_state
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  console_state_e   state;
  console_op_e      op;
  logic             la_pulse, dep_pulse, exam_pulse;
  logic             fsm_we, fsm_oe;
  logic [1:0]       lat_cnt;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_la (
    .clk(CLK), .rst(RESET), .din(btn_la), .pulse(la_pulse));
  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dep (
    .clk(CLK), .rst(RESET), .din(btn_dep), .pulse(dep_pulse));
  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_exam (
    .clk(CLK), .rst(RESET), .din(btn_exam), .pulse(exam_pulse));

  assign op = pick_op(la_pulse, dep_pulse, exam_pulse);

  // Ownership, write and read strobes are registers so reset clears them
  // asynchronously and the RAM port falls straight back to the CPU.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      ma           <= '0;
      mb           <= '0;
      console_owns <= 1'b0;
      fsm_we       <= 1'b0;
      fsm_oe       <= 1'b0;
      lat_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cpu_running) begin
            case (op)
              OP_LA:   state <= ST_LA;
              OP_DEP: begin
                state        <= ST_DEP_WR;
                console_owns <= 1'b1;
                fsm_we       <= 1'b1;
              end
              OP_EXAM: begin
                state        <= ST_EX_RD;
                console_owns <= 1'b1;
                fsm_oe       <= 1'b1;
                lat_cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_LA: begin
          ma    <= sw;
          state <= ST_IDLE;
        end
        ST_DEP_WR: begin
          mb     <= sw;
          fsm_we <= 1'b0;
          state  <= ST_INC;
        end
        ST_EX_RD: begin
          if (lat_cnt == LAT_LAST) state <= ST_EX_CAP;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        ST_EX_CAP: begin
          mb     <= ram_rdata;
          fsm_oe <= 1'b0;
          state  <= ST_INC;
        end
        ST_INC: begin
          ma           <= ma + 12'd1;
          console_owns <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          console_owns <= 1'b0;
          fsm_we       <= 1'b0;
          fsm_oe       <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = console_owns ? ma     : cpu_ram_addr;
  assign ram_wdata = console_owns ? sw     : cpu_ram_wdata;
  assign ram_we    = console_owns ? fsm_we : cpu_ram_we;
  assign ram_oe    = console_owns ? fsm_oe : cpu_ram_oe;
  assign cpu_stall = console_owns;
  assign dbg_state = state;

endmodule

// File: tb/tb_console_mem_ctrl.sv
// Bench for console_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share the
// panel/CPU stimulus, each with its own RAM model and scoreboard queues.
module tb_console_mem_ctrl;
  import pdp8_console_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_running = 1'b0;
  logic [11:0] sw = '0;
  logic        btn_la = 1'b0, btn_dep = 1'b0, btn_exam = 1'b0;
  logic [11:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_we = 1'b0, cpu_oe = 1'b0;

  logic [11:0] rdata1, addr1, wdata1, ma1, mb1;
  logic [11:0] rdata3, addr3, wdata3, ma3, mb3;
  logic        we1, oe1, own1, stall1, we3, oe3, own3, stall3;
  logic [2:0]  st1, st3;

  console_mem_ctrl #(.SYNC_STAGES(2), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .cpu_running(cpu_running), .sw(sw),
    .btn_la(btn_la), .btn_dep(btn_dep), .btn_exam(btn_exam),
    .cpu_ram_addr(cpu_addr), .cpu_ram_wdata(cpu_wdata), .cpu_ram_we(cpu_we),
    .cpu_ram_oe(cpu_oe), .ram_rdata(rdata1), .ram_addr(addr1), .ram_wdata(wdata1),
    .ram_we(we1), .ram_oe(oe1), .console_owns(own1), .cpu_stall(stall1),
    .ma(ma1), .mb(mb1), .dbg_state(st1));

  console_mem_ctrl #(.SYNC_STAGES(2), .RD_LAT(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .cpu_running(cpu_running), .sw(sw),
    .btn_la(btn_la), .btn_dep(btn_dep), .btn_exam(btn_exam),
    .cpu_ram_addr(cpu_addr), .cpu_ram_wdata(cpu_wdata), .cpu_ram_we(cpu_we),
    .cpu_ram_oe(cpu_oe), .ram_rdata(rdata3), .ram_addr(addr3), .ram_wdata(wdata3),
    .ram_we(we3), .ram_oe(oe3), .console_owns(own3), .cpu_stall(stall3),
    .ma(ma3), .mb(mb3), .dbg_state(st3));

  // ---------------- RAM models ----------------
  logic [11:0] mem1 [4096];
  logic [11:0] mem3 [4096];
  logic [11:0] p3 [3];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0, pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (we1) mem1[addr1] <= wdata1;
      if (we3) mem3[addr3] <= wdata3;
    end
    rdata1 <= oe1 ? mem1[addr1] : 12'o0;
    p3[0]  <= oe3 ? mem3[addr3] : 12'o0;
    p3[1]  <= p3[0];
    p3[2]  <= p3[1];
  end
  assign rdata3 = p3[2];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [23:0] wr1_q[$], wr3_q[$], done1_q[$], done3_q[$];
  logic [11:0] exp_ma = '0, exp_mb = '0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%o required=%o", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, inout logic [23:0] q[$], input logic [23:0] act);
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s actual=%o required=<nothing expected>", name, act);
    end else begin
      logic [23:0] e;
      e = q.pop_front();
      checks--;
      check(name, act, e);
    end
  endtask

  logic [2:0] prev1 = 3'(ST_IDLE), prev3 = 3'(ST_IDLE);
  int rd_cnt1 = 0, rd_cnt3 = 0;

  // Monitor: console writes and op completions (return to IDLE).
  always @(negedge clk) begin
    if (rst) begin
      prev1 = 3'(ST_IDLE);
      prev3 = 3'(ST_IDLE);
      rd_cnt1 = 0;
      rd_cnt3 = 0;
    end else begin
      if (we1 && own1) pop_cmp("wr1", wr1_q, {addr1, wdata1});
      if (we3 && own3) pop_cmp("wr3", wr3_q, {addr3, wdata3});
      if (st1 == ST_IDLE && prev1 != ST_IDLE) pop_cmp("done1", done1_q, {ma1, mb1});
      if (st3 == ST_IDLE && prev3 != ST_IDLE) pop_cmp("done3", done3_q, {ma3, mb3});
      if (st1 == ST_EX_RD) rd_cnt1++;
      else if (prev1 == ST_EX_RD) begin check("rd_cycles1", 24'(rd_cnt1), 24'd1); rd_cnt1 = 0; end
      if (st3 == ST_EX_RD) rd_cnt3++;
      else if (prev3 == ST_EX_RD) begin check("rd_cycles3", 24'(rd_cnt3), 24'd3); rd_cnt3 = 0; end
      prev1 = st1;
      prev3 = st3;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    @(posedge clk); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    cycles(1);
    pl_en = 1'b0;
  endtask

  task automatic push_done();
    done1_q.push_back({exp_ma, exp_mb});
    done3_q.push_back({exp_ma, exp_mb});
  endtask

  task automatic pulse_btns(input logic la, input logic dep, input logic ex);
    @(posedge clk); #2;
    btn_la = la; btn_dep = dep; btn_exam = ex;
    cycles(4);
    btn_la = 1'b0; btn_dep = 1'b0; btn_exam = 1'b0;
    cycles(10);
  endtask

  task automatic do_la(input logic [11:0] v);
    sw = v;
    exp_ma = v;
    push_done();
    pulse_btns(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_dep(input logic [11:0] v);
    sw = v;
    wr1_q.push_back({exp_ma, v});
    wr3_q.push_back({exp_ma, v});
    exp_mb = v;
    exp_ma = exp_ma + 12'd1;
    push_done();
    pulse_btns(1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_exam(input logic [11:0] w);
    exp_mb = w;
    exp_ma = exp_ma + 12'd1;
    push_done();
    pulse_btns(1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    cpu_addr = 12'o1234; cpu_wdata = 12'o4321; cpu_we = 1'b1; cpu_oe = 1'b0;
    #1 rst = 1'b1;
    cycles(3);
    check("rst_ma", ma1, 12'o0);
    check("rst_mb", mb1, 12'o0);
    check("rst_owns", own1, 1'b0);
    check("rst_stall", {stall1, stall3}, 2'b00);
    check("rst_state", st1, ST_IDLE);
    check("rst_ram_pass", {addr1, wdata1}, {12'o1234, 12'o4321});
    check("rst_we_pass", {we1, oe1}, 2'b10);
    rst = 1'b0;
    cpu_we = 1'b0;
    cycles(2);

    // Examine with preloaded RAM; CPU drives junk that must be ignored.
    preload(12'o0200, 12'o7402);
    preload(12'o0201, 12'o1234);
    cpu_addr = 12'o7070; cpu_wdata = 12'o6543; cpu_oe = 1'b1;
    do_la(12'o0200);
    do_exam(12'o7402);
    do_exam(12'o1234);
    check("exam_ma_mb1", {ma1, mb1}, {12'o0202, 12'o1234});
    check("exam_ma_mb3", {ma3, mb3}, {12'o0202, 12'o1234});

    // LA / DEP sequence onto cleared locations.
    preload(12'o0200, 12'o0000);
    preload(12'o0201, 12'o0000);
    do_la(12'o0200);
    do_dep(12'o7402);
    do_dep(12'o1234);
    check("dep_ram1", {mem1[12'o0200], mem1[12'o0201]}, {12'o7402, 12'o1234});
    check("dep_ram3", {mem3[12'o0200], mem3[12'o0201]}, {12'o7402, 12'o1234});
    check("dep_ma_mb", {ma1, mb1}, {12'o0202, 12'o1234});

    // Address wrap.
    do_la(12'o7777);
    do_dep(12'o5555);
    check("wrap_ram", mem1[12'o7777], 12'o5555);
    check("wrap_ma", {ma1, ma3}, {12'o0000, 12'o0000});

    // Running lockout: buttons ignored, RAM port follows CPU exactly.
    cpu_running = 1'b1;
    @(posedge clk); #2;
    btn_la = 1'b1; btn_dep = 1'b1; btn_exam = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_addr = 12'o7000 + 12'(i); cpu_wdata = 12'o3030 ^ 12'(i * 7);
      cpu_we = i[0]; cpu_oe = ~i[1];
      if (i == 5) begin btn_la = 1'b0; btn_dep = 1'b0; btn_exam = 1'b0; end
      cycles(1);
      check("lock_port", {addr1, wdata1, we1, oe1, own1},
            {cpu_addr, cpu_wdata, cpu_we, cpu_oe, 1'b0});
    end
    check("lock_ma_mb", {ma1, mb1}, {exp_ma, exp_mb});
    cpu_running = 1'b0; cpu_we = 1'b0; cpu_addr = 12'o7070; cpu_wdata = 12'o6543;
    cycles(5);

    // Priority: LA and DEP on the same edge -> LA only.
    sw = 12'o0300;
    exp_ma = 12'o0300;
    push_done();
    pulse_btns(1'b1, 1'b1, 1'b0);
    check("prio_ma", {ma1, ma3}, {12'o0300, 12'o0300});
    check("prio_mb", mb1, 12'o5555);

    // Reset in the middle of a deposit.
    sw = 12'o4321;
    @(posedge clk); #2;
    btn_dep = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycles(1);
      if (st1 == ST_DEP_WR) found = 1'b1;
    end
    check("midop_reached_dep_wr", 24'(found), 24'd1);
    rst = 1'b1;
    #1;
    check("midop_we", {we1, own1}, 2'b00);
    check("midop_ma_mb", {ma1, mb1}, {12'o0000, 12'o0000});
    check("midop_state", {st1, st3}, {3'(ST_IDLE), 3'(ST_IDLE)});
    cycles(2);
    btn_dep = 1'b0;
    rst = 1'b0;
    exp_ma = 12'o0000; exp_mb = 12'o0000;
    cycles(3);
    do_dep(12'o2222);
    check("post_rst_ram", mem1[12'o0000], 12'o2222);
    check("post_rst_ma_mb", {ma1, mb1}, {12'o0001, 12'o2222});

    cycles(5);
    check("wr1_q_empty", 24'(wr1_q.size()), 24'd0);
    check("wr3_q_empty", 24'(wr3_q.size()), 24'd0);
    check("done1_q_empty", 24'(done1_q.size()), 24'd0);
    check("done3_q_empty", 24'(done3_q.size()), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
